ad9363_cmos_if_tx: RTL



---
 rtl/ad9363_cmos_if_pkg.sv | 26 ++
 rtl/ad9363_tx_fifo.sv | 52 +++++
 rtl/ad9363_cmos_if_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ad9363_cmos_if_pkg.sv
// Shared definitions for the AD9363 CMOS transmit PHY: FSM states, test-mode
// encodings and fixed pattern/ODDR constants.
package ad9363_cmos_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        MODE_USER = 2'd0,
        MODE_RAMP = 2'd1,
        MODE_ALT  = 2'd2,
        MODE_ZERO = 2'd3
    } tx_mode_e;

    localparam logic [11:0] PAT_ALT_I     = 12'hAAA;
    localparam logic [11:0] PAT_ALT_Q     = 12'h555;
    localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;

    // Rising-half / falling-half levels for the clock and frame ODDRs.
    localparam logic ODDR_D1_HI = 1'b1;
    localparam logic ODDR_D2_LO = 1'b0;

endpackage

// File: rtl/ad9363_tx_fifo.sv
// Sample-pair FIFO with first-word fall-through read data, occupancy count
// and a synchronous flush that also drops any write in the same cycle.
module ad9363_tx_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = wr_en & ~full  & ~flush;
    assign w_rd = rd_en & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign count   = r_wr_ptr - r_rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ad9363_cmos_if_tx.sv
// AD9363 1R1T single-port DDR CMOS transmit PHY: buffers user I/Q pairs and
// serializes one pair per clock as I (frame=1) then Q (frame=0).
module ad9363_cmos_if_tx
    import ad9363_cmos_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILL_LEVEL = 4
) (
    input  logic                  tx_data_clk,
    input  logic                  rst_n,
    input  logic                  tx_enable,
    input  logic [1:0]            test_mode,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    input  logic [DATA_WIDTH-1:0] dac_data_i1,
    input  logic [DATA_WIDTH-1:0] dac_data_q1,
    output logic                  tx_status,
    output logic [15:0]           underflow_cnt,
    output logic                  tx_clk_out,
    output logic                  tx_frame_out,
    output logic [DATA_WIDTH-1:0] tx_data_out
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e             r_state;
    tx_state_e             w_state_nxt;
    tx_mode_e              w_mode;
    logic                  w_user;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [2*DATA_WIDTH-1:0] w_fifo_rd;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_underflow;
    logic                  w_clear;
    logic                  w_ramp_inc;
    logic [DATA_WIDTH-1:0] w_out_i;
    logic [DATA_WIDTH-1:0] w_out_q;

    logic                  r_tx_status;
    logic [15:0]           r_underflow_cnt;
    logic [DATA_WIDTH-1:0] r_ramp;
    logic [DATA_WIDTH-1:0] r_out_i;
    logic [DATA_WIDTH-1:0] r_out_q;
    logic [DATA_WIDTH-1:0] r_oddr_i;
    logic [DATA_WIDTH-1:0] r_oddr_q;
    logic                  r_oddr_frame;

    assign w_mode = tx_mode_e'(test_mode);
    assign w_user = (w_mode == MODE_USER);

    // Gated by rst_n so the handshake is closed while reset is held.
    assign dac_ready = rst_n & tx_enable & w_user & ~w_full;
    assign w_wr      = dac_valid & dac_ready;

    ad9363_tx_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (tx_data_clk),
        .rst_n   (rst_n),
        .flush   (~tx_enable),
        .wr_en   (w_wr),
        .wr_data ({dac_data_i1, dac_data_q1}),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge tx_data_clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        w_clear     = 1'b0;
        w_ramp_inc  = 1'b0;
        w_out_i     = '0;
        w_out_q     = '0;
        if (!tx_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FILL;
                    w_clear     = 1'b1;
                end
                ST_FILL: begin
                    if (w_count >= CW'(FILL_LEVEL) || !w_user) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    case (w_mode)
                        MODE_USER: begin
                            if (w_empty) begin
                                w_underflow = 1'b1;
                                w_state_nxt = ST_FILL;
                            end else begin
                                w_pop              = 1'b1;
                                {w_out_i, w_out_q} = w_fifo_rd;
                            end
                        end
                        MODE_RAMP: begin
                            w_out_i    = r_ramp;
                            w_out_q    = ~r_ramp;
                            w_ramp_inc = 1'b1;
                        end
                        MODE_ALT: begin
                            w_out_i = DATA_WIDTH'(PAT_ALT_I);
                            w_out_q = DATA_WIDTH'(PAT_ALT_Q);
                        end
                        MODE_ZERO: ;
                    endcase
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_data_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_status     <= 1'b0;
            r_underflow_cnt <= '0;
            r_ramp          <= '0;
            r_out_i         <= '0;
            r_out_q         <= '0;
        end else begin
            if (w_clear) begin
                r_tx_status     <= 1'b0;
                r_underflow_cnt <= '0;
            end else if (w_underflow) begin
                r_tx_status <= 1'b1;
                if (r_underflow_cnt != UNDERFLOW_MAX) r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
            if (w_ramp_inc) r_ramp <= r_ramp + 1'b1;
            r_out_i <= w_out_i;
            r_out_q <= w_out_q;
        end
    end

    // SAME_EDGE ODDR model: both halves captured on the rising edge, then
    // the pin shows D1 while the clock is high and D2 while it is low.
    always_ff @(posedge tx_data_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oddr_i     <= '0;
            r_oddr_q     <= '0;
            r_oddr_frame <= 1'b0;
        end else begin
            r_oddr_i     <= r_out_i;
            r_oddr_q     <= r_out_q;
            r_oddr_frame <= ODDR_D1_HI;
        end
    end

    assign tx_data_out   = tx_data_clk ? r_oddr_i     : r_oddr_q;
    assign tx_frame_out  = tx_data_clk ? r_oddr_frame : ODDR_D2_LO;
    assign tx_clk_out    = tx_data_clk ? ODDR_D1_HI   : ODDR_D2_LO;
    assign tx_status     = r_tx_status;
    assign underflow_cnt = r_underflow_cnt;

endmodule
